// File: rtl/axi_lite_csr_pkg.sv
// Shared types and helpers for the AXI-Lite CSR subordinate.
// Covers response codes, FSM state encodings and the address decode helpers.
package axi_lite_csr_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_CAPT  = 2'd2,
    R_RESP  = 2'd3
  } rd_state_e;

  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] limit);
    return addr < limit;
  endfunction

  // Byte offset bits are dropped; the caller truncates to its index width.
  function automatic logic [63:0] word_idx(input logic [63:0] addr, input int ofs);
    return addr >> ofs;
  endfunction

endpackage

// File: rtl/axi_lite_csr_sub.sv
// AXI4-Lite to CSR bridge: write strobe + B one cycle after AW/W complete, read response three cycles after AR.
// bready/rready low holds the response and blocks new AW/W/AR until the handshake.
module axi_lite_csr_sub
  import axi_lite_csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16,
  localparam int STRB_W    = DATA_WIDTH / 8,
  localparam int IDX_W     = $clog2(NUM_REGS),
  localparam int OFS       = $clog2(STRB_W)
) (
  input  logic                  s_axi_clk,
  input  logic                  s_axi_resetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0]     s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  csr_wr_en,
  output logic [IDX_W-1:0]      csr_wr_idx,
  output logic [DATA_WIDTH-1:0] csr_wr_data,
  output logic [STRB_W-1:0]     csr_wr_strb,
  output logic                  csr_rd_en,
  output logic [IDX_W-1:0]      csr_rd_idx,
  input  logic [DATA_WIDTH-1:0] csr_rd_data
);

  localparam logic [63:0] LIMIT = 64'(NUM_REGS * STRB_W);

  wr_state_e             r_wstate;
  rd_state_e             r_rstate;
  logic                  r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic                  r_csr_wr_en, r_csr_rd_en, r_rd_ok;
  logic [1:0]            r_bresp, r_rresp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata, r_csr_wr_data;
  logic [STRB_W-1:0]     r_wstrb, r_csr_wr_strb;
  logic [IDX_W-1:0]      r_csr_wr_idx, r_csr_rd_idx;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_have_a, w_have_d, w_wr_ok, w_rd_ok;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;

  assign w_aw_hs  = s_axi_awvalid & r_awready;
  assign w_w_hs   = s_axi_wvalid & r_wready;
  assign w_ar_hs  = s_axi_arvalid & r_arready;
  assign w_have_a = w_aw_hs | (r_wstate == W_HAVE_A);
  assign w_have_d = w_w_hs | (r_wstate == W_HAVE_D);

  // Completing beat may arrive on the bus this cycle or have been latched earlier.
  assign w_waddr = w_aw_hs ? s_axi_awaddr : r_awaddr;
  assign w_wdata = w_w_hs ? s_axi_wdata : r_wdata;
  assign w_wstrb = w_w_hs ? s_axi_wstrb : r_wstrb;
  assign w_wr_ok = addr_in_range(64'(w_waddr), LIMIT);
  assign w_rd_ok = addr_in_range(64'(s_axi_araddr), LIMIT);

  always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      r_wstate      <= W_IDLE;
      r_awready     <= 1'b0;
      r_wready      <= 1'b0;
      r_bvalid      <= 1'b0;
      r_bresp       <= OKAY;
      r_awaddr      <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_csr_wr_en   <= 1'b0;
      r_csr_wr_idx  <= '0;
      r_csr_wr_data <= '0;
      r_csr_wr_strb <= '0;
    end else begin
      r_csr_wr_en <= 1'b0;
      case (r_wstate)
        W_IDLE, W_HAVE_A, W_HAVE_D: begin
          if (w_aw_hs) r_awaddr <= s_axi_awaddr;
          if (w_w_hs) begin
            r_wdata <= s_axi_wdata;
            r_wstrb <= s_axi_wstrb;
          end
          if (w_have_a && w_have_d) begin
            r_csr_wr_en   <= w_wr_ok & (|w_wstrb);
            r_csr_wr_idx  <= IDX_W'(word_idx(64'(w_waddr), OFS));
            r_csr_wr_data <= w_wdata;
            r_csr_wr_strb <= w_wstrb;
            r_bvalid      <= 1'b1;
            r_bresp       <= w_wr_ok ? OKAY : SLVERR;
            r_awready     <= 1'b0;
            r_wready      <= 1'b0;
            r_wstate      <= W_RESP;
          end else if (w_have_a) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_HAVE_A;
          end else if (w_have_d) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_wstate  <= W_HAVE_D;
          end else begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      r_rstate     <= R_IDLE;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rresp      <= OKAY;
      r_rdata      <= '0;
      r_rd_ok      <= 1'b0;
      r_csr_rd_en  <= 1'b0;
      r_csr_rd_idx <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arready    <= 1'b0;
            r_rd_ok      <= w_rd_ok;
            r_csr_rd_en  <= w_rd_ok;
            r_csr_rd_idx <= IDX_W'(word_idx(64'(s_axi_araddr), OFS));
            r_rstate     <= R_ISSUE;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_ISSUE: begin
          r_csr_rd_en <= 1'b0;
          r_rstate    <= R_CAPT;
        end
        R_CAPT: begin
          r_rdata  <= r_rd_ok ? csr_rd_data : '0;
          r_rresp  <= r_rd_ok ? OKAY : SLVERR;
          r_rvalid <= 1'b1;
          r_rstate <= R_RESP;
        end
        R_RESP: begin
          if (s_axi_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign csr_wr_en     = r_csr_wr_en;
  assign csr_wr_idx    = r_csr_wr_idx;
  assign csr_wr_data   = r_csr_wr_data;
  assign csr_wr_strb   = r_csr_wr_strb;
  assign csr_rd_en     = r_csr_rd_en;
  assign csr_rd_idx    = r_csr_rd_idx;

endmodule
